eeg_pad_sched: RTL and testbench



---
 rtl/eeg_pad_sched.sv | 127 ++++++++++++
 tb/tb_eeg_pad_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeg_pad_sched.sv
// Half-duplex pad-bus scheduler: round-robin between inbound host bursts and
// outbound result bursts, with pad turnaround and unregistered handshake pass-through.
module eeg_pad_sched #(
  parameter int CHIP_DAT_DW = 8,
  parameter int CHIP_OUT_DW = 8,
  parameter int TURN_CYC    = 2,
  parameter int MAX_BURST   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   HST_REQ,
  input  logic                   HST_VLD,
  input  logic                   HST_LST,
  output logic                   HST_RDY,
  input  logic [CHIP_DAT_DW-1:0] HST_DAT,
  input  logic                   HST_CMD,
  output logic                   HST_DIR,
  output logic                   HST_OVLD,
  output logic                   HST_OLST,
  output logic                   HST_OBRK,
  input  logic                   HST_ORDY,
  output logic [CHIP_OUT_DW-1:0] HST_ODAT,
  output logic                   BUF_DAT_VLD,
  output logic                   BUF_DAT_LST,
  output logic                   BUF_DAT_CMD,
  output logic [CHIP_DAT_DW-1:0] BUF_DAT_DAT,
  input  logic                   BUF_DAT_RDY,
  input  logic                   BUF_OUT_VLD,
  input  logic                   BUF_OUT_LST,
  input  logic [CHIP_OUT_DW-1:0] BUF_OUT_DAT,
  output logic                   BUF_OUT_RDY,
  output logic                   SCH_BUSY
);

  typedef enum logic [2:0] {IDLE, RX, TURN_TX, TX, TURN_RX} state_t;
  typedef enum logic {G_RX, G_TX} grant_t;

  localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);
  localparam logic [7:0] CAP_LAST  = 8'(MAX_BURST - 1);

  state_t     state, state_nxt;
  grant_t     last_grant, last_grant_nxt;
  logic [3:0] turn_cnt, turn_cnt_nxt;
  logic [7:0] burst_cnt, burst_cnt_nxt;
  logic       rx_acc, tx_acc;

  // Payload paths are plain wires; only the handshakes depend on the grant.
  assign BUF_DAT_DAT = HST_DAT;
  assign BUF_DAT_LST = HST_LST;
  assign BUF_DAT_CMD = HST_CMD;
  assign HST_ODAT    = BUF_OUT_DAT;
  assign HST_OLST    = BUF_OUT_LST;

  assign BUF_DAT_VLD = (state == RX) && HST_VLD;
  assign HST_RDY     = (state == RX) && BUF_DAT_RDY;
  assign HST_OVLD    = (state == TX) && BUF_OUT_VLD;
  assign BUF_OUT_RDY = (state == TX) && HST_ORDY;
  assign HST_OBRK    = HST_OVLD && !BUF_OUT_LST && (burst_cnt == CAP_LAST);
  assign HST_DIR     = (state == TURN_TX) || (state == TX);
  assign SCH_BUSY    = (state != IDLE);

  assign rx_acc = BUF_DAT_VLD && BUF_DAT_RDY;
  assign tx_acc = HST_OVLD && HST_ORDY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= G_TX;
      turn_cnt   <= '0;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      turn_cnt   <= turn_cnt_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    turn_cnt_nxt   = turn_cnt;
    burst_cnt_nxt  = burst_cnt;
    case (state)
      IDLE: begin
        // last_grant resets to TX so the first contested grant goes to RX
        if (HST_REQ && (!BUF_OUT_VLD || last_grant == G_TX)) begin
          state_nxt = RX;
        end else if (BUF_OUT_VLD) begin
          state_nxt    = TURN_TX;
          turn_cnt_nxt = '0;
        end
      end
      RX: begin
        last_grant_nxt = G_RX;
        if (rx_acc && HST_LST) state_nxt = IDLE;
      end
      TURN_TX: begin
        if (turn_cnt == TURN_LAST) begin
          state_nxt     = TX;
          turn_cnt_nxt  = '0;
          burst_cnt_nxt = '0;
        end else begin
          turn_cnt_nxt = turn_cnt + 4'd1;
        end
      end
      TX: begin
        last_grant_nxt = G_TX;
        if (tx_acc && burst_cnt != 8'hFF) burst_cnt_nxt = burst_cnt + 8'd1;
        if (tx_acc && (BUF_OUT_LST || HST_OBRK)) begin
          state_nxt    = TURN_RX;
          turn_cnt_nxt = '0;
        end
      end
      TURN_RX: begin
        if (turn_cnt == TURN_LAST) begin
          state_nxt    = IDLE;
          turn_cnt_nxt = '0;
        end else begin
          turn_cnt_nxt = turn_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_eeg_pad_sched.sv
// Randomized bench for eeg_pad_sched: behavioural host/buffer endpoints,
// transaction scoreboards and per-scenario timing/arbitration checks.
module tb_eeg_pad_sched;
  localparam int DW = 8, OW = 8, TURN_CYC = 2, MAX_BURST = 16;

  typedef struct packed {logic [DW-1:0] dat; logic cmd; logic lst;} ib_t;
  typedef struct packed {logic [OW-1:0] dat; logic lst; logic brk;} ob_t;
  typedef struct packed {logic dir; logic busy; logic hrdy; logic ovld;} tr_t;

  logic clk, rst_n;
  logic HST_REQ, HST_VLD, HST_LST, HST_RDY, HST_CMD, HST_DIR;
  logic HST_OVLD, HST_OLST, HST_OBRK, HST_ORDY;
  logic [DW-1:0] HST_DAT, BUF_DAT_DAT;
  logic [OW-1:0] HST_ODAT, BUF_OUT_DAT;
  logic BUF_DAT_VLD, BUF_DAT_LST, BUF_DAT_CMD, BUF_DAT_RDY;
  logic BUF_OUT_VLD, BUF_OUT_LST, BUF_OUT_RDY, SCH_BUSY;

  eeg_pad_sched #(.CHIP_DAT_DW(DW), .CHIP_OUT_DW(OW), .TURN_CYC(TURN_CYC), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .HST_REQ(HST_REQ), .HST_VLD(HST_VLD), .HST_LST(HST_LST), .HST_RDY(HST_RDY),
    .HST_DAT(HST_DAT), .HST_CMD(HST_CMD), .HST_DIR(HST_DIR),
    .HST_OVLD(HST_OVLD), .HST_OLST(HST_OLST), .HST_OBRK(HST_OBRK), .HST_ORDY(HST_ORDY),
    .HST_ODAT(HST_ODAT),
    .BUF_DAT_VLD(BUF_DAT_VLD), .BUF_DAT_LST(BUF_DAT_LST), .BUF_DAT_CMD(BUF_DAT_CMD),
    .BUF_DAT_DAT(BUF_DAT_DAT), .BUF_DAT_RDY(BUF_DAT_RDY),
    .BUF_OUT_VLD(BUF_OUT_VLD), .BUF_OUT_LST(BUF_OUT_LST), .BUF_OUT_DAT(BUF_OUT_DAT),
    .BUF_OUT_RDY(BUF_OUT_RDY), .SCH_BUSY(SCH_BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int p_hvld = 100, p_brdy = 100, p_ordy = 100, p_ovld = 100;
  int ob_cnt = 0;
  logic prev_busy = 1'b0;

  ib_t  in_q[$], in_sent[$], rx_got[$];
  ob_t  out_q[$], out_sent[$], tx_got[$];
  tr_t  trace[$];
  logic grants[$];  // 0 = RX grant, 1 = TX grant

  function automatic bit roll(input int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic drive();
    HST_REQ = (in_q.size() > 0);
    HST_VLD = (in_q.size() > 0) && roll(p_hvld);
    if (in_q.size() > 0) {HST_DAT, HST_CMD, HST_LST} = in_q[0];
    else {HST_DAT, HST_CMD, HST_LST} = {DW'($urandom), 2'b00};
    BUF_OUT_VLD = (out_q.size() > 0) && roll(p_ovld);
    if (out_q.size() > 0) {BUF_OUT_DAT, BUF_OUT_LST} = {out_q[0].dat, out_q[0].lst};
    else {BUF_OUT_DAT, BUF_OUT_LST} = {OW'($urandom), 1'b0};
    BUF_DAT_RDY = roll(p_brdy);
    HST_ORDY    = roll(p_ordy);
  endtask

  task automatic push_in_burst(input int len);
    ib_t b;
    for (int i = 0; i < len; i++) begin
      b.dat = DW'($urandom); b.cmd = 1'($urandom); b.lst = (i == len - 1);
      in_q.push_back(b); in_sent.push_back(b);
    end
  endtask

  // Reference: a grant ends on LST or after MAX_BURST beats; cut beat flags brk.
  task automatic push_out_burst(input int len);
    ob_t b;
    for (int i = 0; i < len; i++) begin
      b.dat = OW'($urandom); b.lst = (i == len - 1);
      ob_cnt++;
      b.brk = !b.lst && (ob_cnt == MAX_BURST);
      if (b.lst || b.brk) ob_cnt = 0;
      out_q.push_back(b); out_sent.push_back(b);
    end
  endtask

  // Entered at posedge+1 with inputs driven; samples, advances one clock, redrives.
  task automatic cycle();
    logic rx_acc, tx_acc;
    tr_t t;
    #2;
    rx_acc = HST_VLD && HST_RDY;
    tx_acc = HST_OVLD && HST_ORDY;
    if (rx_acc) rx_got.push_back({BUF_DAT_DAT, BUF_DAT_CMD, BUF_DAT_LST});
    if (tx_acc) tx_got.push_back({HST_ODAT, HST_OLST, HST_OBRK});
    t.dir = HST_DIR; t.busy = SCH_BUSY; t.hrdy = HST_RDY; t.ovld = HST_OVLD;
    trace.push_back(t);
    if (SCH_BUSY && !prev_busy) grants.push_back(HST_DIR);
    prev_busy = SCH_BUSY;
    @(posedge clk); #1;
    if (rx_acc) void'(in_q.pop_front());
    if (tx_acc) void'(out_q.pop_front());
    drive();
  endtask

  task automatic run_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (in_q.size() == 0 && out_q.size() == 0 && !prev_busy) begin ok = 1'b1; break; end
    end
  endtask

  // Unsent beats are abandoned by the reset; the reference forgets them too.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (in_q.size()) void'(in_sent.pop_back());
    repeat (out_q.size()) void'(out_sent.pop_back());
    in_q.delete(); out_q.delete(); ob_cnt = 0;
    drive();
    prev_busy = 1'b0; grants.delete(); trace.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    HST_REQ = 1; HST_VLD = 1; BUF_OUT_VLD = 1; BUF_DAT_RDY = 1; HST_ORDY = 1;
    HST_LST = 0; HST_CMD = 0; HST_DAT = '0; BUF_OUT_LST = 0; BUF_OUT_DAT = '0;
    #3;
    n_checks++;
    if ({HST_RDY, HST_DIR, HST_OVLD, HST_OBRK, BUF_DAT_VLD, BUF_OUT_RDY, SCH_BUSY} !== 7'b0)
      $display("FAIL reset_outputs got %b exp 0000000",
               {HST_RDY, HST_DIR, HST_OVLD, HST_OBRK, BUF_DAT_VLD, BUF_OUT_RDY, SCH_BUSY});
    else n_pass++;
    do_reset();
    #1;
    n_checks++;
    if ({HST_DIR, SCH_BUSY} !== 2'b00) $display("FAIL post_reset_idle got %b exp 00", {HST_DIR, SCH_BUSY});
    else n_pass++;
  endtask

  task automatic test_rx_burst();
    int base;
    base = rx_got.size();
    trace.delete();
    push_in_burst(4);
    drive();
    repeat (6) cycle();
    for (int k = 0; k < trace.size(); k++) begin
      logic eb;
      eb = (k >= 1 && k <= 4);
      n_checks++;
      if ({trace[k].dir, trace[k].busy, trace[k].hrdy} !== {1'b0, eb, eb})
        $display("FAIL rx_timing[%0d] got dir/busy/rdy %b exp %b", k,
                 {trace[k].dir, trace[k].busy, trace[k].hrdy}, {1'b0, eb, eb});
      else n_pass++;
    end
    n_checks++;
    if (rx_got.size() - base !== 4) $display("FAIL rx_beats got %0d exp 4", rx_got.size() - base);
    else n_pass++;
  endtask

  task automatic test_tx_burst();
    trace.delete();
    push_out_burst(3);
    drive();
    repeat (2 * TURN_CYC + 5) cycle();
    for (int k = 0; k < trace.size(); k++) begin
      logic ed, eo, eb;
      ed = (k >= 1 && k <= TURN_CYC + 3);
      eo = (k >= TURN_CYC + 1 && k <= TURN_CYC + 3);
      eb = (k >= 1 && k <= 2 * TURN_CYC + 3);
      n_checks++;
      if ({trace[k].dir, trace[k].ovld, trace[k].busy} !== {ed, eo, eb})
        $display("FAIL tx_timing[%0d] got dir/ovld/busy %b exp %b", k,
                 {trace[k].dir, trace[k].ovld, trace[k].busy}, {ed, eo, eb});
      else n_pass++;
    end
  endtask

  task automatic test_cap();
    int base;
    bit ok;
    base = tx_got.size();
    grants.delete();
    push_out_burst(20);
    drive();
    run_drain(300, ok);
    n_checks++;
    if (!ok) $display("FAIL cap_drain got timeout exp idle");
    else n_pass++;
    n_checks++;
    if (grants.size() !== 2 || grants[0] !== 1'b1 || grants[1] !== 1'b1)
      $display("FAIL cap_grants got n=%0d exp 2 TX grants", grants.size());
    else n_pass++;
    n_checks++;
    if (tx_got.size() < base + 20) $display("FAIL cap_beats got %0d exp 20", tx_got.size() - base);
    else if ({tx_got[base+15].brk, tx_got[base+15].lst, tx_got[base+19].lst, tx_got[base+19].brk} !== 4'b1010)
      $display("FAIL cap_flags got %b exp 1010",
               {tx_got[base+15].brk, tx_got[base+15].lst, tx_got[base+19].lst, tx_got[base+19].brk});
    else n_pass++;
  endtask

  task automatic test_alternate();
    bit ok;
    do_reset();
    p_hvld = 70; p_brdy = 70; p_ordy = 70; p_ovld = 100;
    for (int i = 0; i < 4; i++) push_in_burst($urandom_range(4, 1));
    for (int i = 0; i < 4; i++) push_out_burst($urandom_range(5, 1));
    drive();
    run_drain(600, ok);
    n_checks++;
    if (!ok) $display("FAIL alt_drain got timeout exp idle");
    else n_pass++;
    n_checks++;
    if (grants.size() !== 8) $display("FAIL alt_grant_count got %0d exp 8", grants.size());
    else n_pass++;
    for (int i = 0; i < grants.size(); i++) begin
      n_checks++;
      if (grants[i] !== 1'(i % 2)) $display("FAIL alt_grant[%0d] got %b exp %b", i, grants[i], 1'(i % 2));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int base;
    bit ok;
    p_hvld = 100; p_brdy = 100; p_ordy = 100; p_ovld = 100;
    base = rx_got.size();
    push_in_burst(6);
    drive();
    for (int i = 0; i < 50 && rx_got.size() < base + 2; i++) cycle();
    p_brdy = 0;
    drive();
    repeat (3) cycle();
    n_checks++;
    if (rx_got.size() !== base + 2) $display("FAIL bp_stall got %0d exp 2", rx_got.size() - base);
    else n_pass++;
    p_brdy = 100;
    drive();
    run_drain(100, ok);
    n_checks++;
    if (!ok || rx_got.size() !== base + 6) $display("FAIL bp_resume got %0d exp 6", rx_got.size() - base);
    else n_pass++;
    p_hvld = 60; p_brdy = 50; p_ordy = 50; p_ovld = 60;
    for (int i = 0; i < 6; i++) begin
      push_in_burst($urandom_range(6, 1));
      push_out_burst($urandom_range(20, 1));
    end
    drive();
    run_drain(4000, ok);
    n_checks++;
    if (!ok) $display("FAIL bp_drain got timeout exp idle");
    else n_pass++;
  endtask

  task automatic test_reset_mid_tx();
    int base;
    bit ok;
    do_reset();
    p_hvld = 100; p_brdy = 100; p_ordy = 100; p_ovld = 100;
    base = tx_got.size();
    push_out_burst(8);
    drive();
    for (int i = 0; i < 50 && tx_got.size() < base + 4; i++) cycle();
    #1;
    n_checks++;
    if (HST_OVLD !== 1'b1) $display("FAIL rst_pre_beat5 got ovld %b exp 1", HST_OVLD);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({HST_DIR, HST_OVLD, SCH_BUSY, BUF_OUT_RDY} !== 4'b0)
      $display("FAIL rst_async_clear got %b exp 0000", {HST_DIR, HST_OVLD, SCH_BUSY, BUF_OUT_RDY});
    else n_pass++;
    do_reset();
    push_in_burst(3);
    push_out_burst(2);
    drive();
    run_drain(200, ok);
    n_checks++;
    if (!ok || grants.size() !== 2 || grants[0] !== 1'b0 || grants[1] !== 1'b1)
      $display("FAIL rst_resume_grants got n=%0d first=%b exp RX then TX", grants.size(),
               grants.size() > 0 ? grants[0] : 1'bx);
    else n_pass++;
  endtask

  task automatic test_data_integrity();
    n_checks++;
    if (rx_got.size() !== in_sent.size()) $display("FAIL in_count got %0d exp %0d", rx_got.size(), in_sent.size());
    else n_pass++;
    for (int i = 0; i < rx_got.size() && i < in_sent.size(); i++) begin
      n_checks++;
      if (rx_got[i] !== in_sent[i]) $display("FAIL in_beat[%0d] got %h exp %h", i, rx_got[i], in_sent[i]);
      else n_pass++;
    end
    n_checks++;
    if (tx_got.size() !== out_sent.size()) $display("FAIL out_count got %0d exp %0d", tx_got.size(), out_sent.size());
    else n_pass++;
    for (int i = 0; i < tx_got.size() && i < out_sent.size(); i++) begin
      n_checks++;
      if (tx_got[i] !== out_sent[i]) $display("FAIL out_beat[%0d] got %h exp %h", i, tx_got[i], out_sent[i]);
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rx_burst();
    test_tx_burst();
    test_cap();
    test_alternate();
    test_backpressure();
    test_reset_mid_tx();
    test_data_integrity();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
